execute_stage: RTL and testbench

- Single-issue execute/memory/writeback stage of the rv32i pipeline, directly downstream of the issue stage.
- Consumes one MicroCode plus two operand values per exe_en pulse.
- Computes ALU, branch and jump results, performs loads and stores over a valid/grant data-memory port, and returns register writeback.
- Resolves branch prediction and raises pred_miss with a redirect target.

---
 rtl/execute_stage_pkg.sv | 49 ++++
 rtl/execute_stage_if.sv | 23 ++
 rtl/execute_stage_alu_unit.sv | 48 ++++
 rtl/execute_stage.sv | 181 ++++++++++++++++++
 tb/tb_execute_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared rv32 execute-stage types: op classes, ALU ops, funct3 codes, FSM states, MicroCode.
package execute_stage_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ADDR_BITS = 5;

  typedef enum logic [2:0] {
    OP_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE
  } op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} mem_state_e;

  // imm_sel marks I-type ALU forms, where operand 2 is the immediate.
  typedef struct packed {
    op_class_e                op_class;
    alu_op_e                  alu_op;
    logic [2:0]               funct3;
    logic                     imm_sel;
    logic [XLEN-1:0]          imm;
    logic [XLEN-1:0]          pc;
    logic [REG_ADDR_BITS-1:0] rd_addr;
    logic                     rd_we;
    logic                     pred_taken;
    logic [XLEN-1:0]          pred_target;
  } micro_code_t;

endpackage

// File: rtl/execute_stage_if.sv
// Data-memory valid/grant port between the execute stage and the memory.
interface execute_stage_if #(
  parameter int unsigned DMEM_ADDR_BITS = 32
);
  logic                      dmem_req;
  logic                      dmem_we;
  logic [DMEM_ADDR_BITS-1:0] dmem_addr;
  logic [3:0]                dmem_be;
  logic [31:0]               dmem_wdata;
  logic                      dmem_gnt;
  logic                      dmem_rvalid;
  logic [31:0]               dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/execute_stage_alu_unit.sv
// Combinational ALU and branch comparator.
module alu_unit
  import execute_stage_pkg::*;
(
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  output logic            taken
);
  logic [4:0] shamt;
  assign shamt = b[4:0];

  // ALU result select; arithmetic wraps mod 2^32
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  // Branch condition from funct3
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (cmp_a == cmp_b);
      F3_BNE:  taken = (cmp_a != cmp_b);
      F3_BLT:  taken = ($signed(cmp_a) <  $signed(cmp_b));
      F3_BGE:  taken = ($signed(cmp_a) >= $signed(cmp_b));
      F3_BLTU: taken = (cmp_a <  cmp_b);
      F3_BGEU: taken = (cmp_a >= cmp_b);
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// rv32i execute/memory/writeback stage: ALU, branch resolution, load/store FSM.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exe_en,
  input  micro_code_t              exe_microcode,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  output logic                     exe_busy,
  output logic                     rd_en,
  output logic [REG_ADDR_BITS-1:0] rd_addr,
  output logic [XLEN-1:0]          rd_data,
  output logic                     pred_miss,
  output logic [XLEN-1:0]          redirect_pc,
  execute_stage_if.master          dmem
);
  mem_state_e               state;
  logic [1:0]               ea_lo_q;
  logic [2:0]               funct3_q;
  logic                     is_store_q;
  logic [REG_ADDR_BITS-1:0] ld_rd_q;
  logic                     ld_we_q;

  logic            accept, is_mem, is_store, wb_en;
  logic [XLEN-1:0] op2, alu_result, ea, pc_plus4, target, wb_value;
  logic [XLEN-1:0] actual_next, predicted_next;
  logic            br_taken, taken, miss;
  logic [XLEN-1:0] mem_addr, st_wdata, ld_value;
  logic [3:0]      st_be;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;

  assign is_store = (exe_microcode.op_class == OP_STORE);
  assign is_mem   = (exe_microcode.op_class == OP_LOAD) | is_store;
  assign accept   = exe_en & (state == ST_IDLE) & ~pred_miss;
  assign exe_busy = (state != ST_IDLE) | (accept & is_mem);

  assign op2      = exe_microcode.imm_sel ? exe_microcode.imm : rs2_data;
  assign ea       = rs1_data + exe_microcode.imm;
  assign pc_plus4 = exe_microcode.pc + 32'd4;
  assign wb_en    = exe_microcode.rd_we & (exe_microcode.rd_addr != '0)
                  & (exe_microcode.op_class != OP_BRANCH);

  alu_unit u_alu (
    .alu_op (exe_microcode.alu_op),
    .a      (rs1_data),
    .b      (op2),
    .result (alu_result),
    .funct3 (exe_microcode.funct3),
    .cmp_a  (rs1_data),
    .cmp_b  (rs2_data),
    .taken  (br_taken)
  );

  // Writeback value and control-flow target per op class
  always_comb begin
    wb_value = alu_result;
    taken    = 1'b0;
    target   = exe_microcode.pc + exe_microcode.imm;
    case (exe_microcode.op_class)
      OP_LUI:    wb_value = exe_microcode.imm;
      OP_AUIPC:  wb_value = exe_microcode.pc + exe_microcode.imm;
      OP_JAL:    begin wb_value = pc_plus4; taken = 1'b1; end
      OP_JALR:   begin wb_value = pc_plus4; taken = 1'b1; target = ea & ~32'd1; end
      OP_BRANCH: taken = br_taken;
      default:   wb_value = alu_result;
    endcase
  end

  assign actual_next    = taken ? target : pc_plus4;
  assign predicted_next = exe_microcode.pred_taken ? exe_microcode.pred_target : pc_plus4;
  assign miss           = (actual_next != predicted_next);

  // Store lanes and size-aligned address from the effective address
  always_comb begin
    mem_addr = {ea[XLEN-1:2], 2'b00};
    st_be    = 4'b1111;
    st_wdata = rs2_data;
    case (exe_microcode.funct3[1:0])
      2'b00: begin
        mem_addr = ea;
        st_be    = 4'b0001 << ea[1:0];
        st_wdata = rs2_data << {ea[1:0], 3'b000};
      end
      2'b01: begin
        mem_addr = {ea[XLEN-1:1], 1'b0};
        st_be    = 4'b0011 << {ea[1], 1'b0};
        st_wdata = rs2_data << {ea[1], 4'b0000};
      end
      default: begin
        mem_addr = {ea[XLEN-1:2], 2'b00};
        st_be    = 4'b1111;
        st_wdata = rs2_data;
      end
    endcase
  end

  // Load lane extraction and extension
  assign ld_b = 8'(dmem.dmem_rdata >> {ea_lo_q, 3'b000});
  assign ld_h = 16'(dmem.dmem_rdata >> {ea_lo_q[1], 4'b0000});
  always_comb begin
    ld_value = dmem.dmem_rdata;
    case (funct3_q)
      F3_LB:   ld_value = {{24{ld_b[7]}}, ld_b};
      F3_LH:   ld_value = {{16{ld_h[15]}}, ld_h};
      F3_LBU:  ld_value = {24'd0, ld_b};
      F3_LHU:  ld_value = {16'd0, ld_h};
      default: ld_value = dmem.dmem_rdata;
    endcase
  end

  // Memory FSM plus registered writeback and redirect outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      ea_lo_q         <= '0;
      funct3_q        <= '0;
      is_store_q      <= 1'b0;
      ld_rd_q         <= '0;
      ld_we_q         <= 1'b0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      rd_data         <= '0;
      pred_miss       <= 1'b0;
      redirect_pc     <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
    end else begin
      rd_en     <= 1'b0;
      pred_miss <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_mem) begin
            state           <= ST_REQ;
            ea_lo_q         <= ea[1:0];
            funct3_q        <= exe_microcode.funct3;
            is_store_q      <= is_store;
            ld_rd_q         <= exe_microcode.rd_addr;
            ld_we_q         <= wb_en & ~is_store;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= is_store;
            dmem.dmem_addr  <= DMEM_ADDR_BITS'(mem_addr);
            dmem.dmem_be    <= st_be;
            dmem.dmem_wdata <= st_wdata;
          end else if (accept) begin
            rd_en   <= wb_en;
            rd_addr <= exe_microcode.rd_addr;
            rd_data <= wb_value;
            if (miss) begin
              pred_miss   <= 1'b1;
              redirect_pc <= actual_next;
            end
          end
        end
        ST_REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            state         <= is_store_q ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            rd_en   <= ld_we_q;
            rd_addr <= ld_rd_q;
            rd_data <= ld_value;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            exe_en = 1'b0;
  micro_code_t     exe_microcode = '0;
  logic [31:0]     rs1_data = '0;
  logic [31:0]     rs2_data = '0;
  logic            exe_busy;
  logic            rd_en;
  logic [4:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            pred_miss;
  logic [31:0]     redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

  execute_stage_if #(.DMEM_ADDR_BITS(32)) dmem_bus ();

  execute_stage #(.DMEM_ADDR_BITS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exe_en        (exe_en),
    .exe_microcode (exe_microcode),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .exe_busy      (exe_busy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .pred_miss     (pred_miss),
    .redirect_pc   (redirect_pc),
    .dmem          (dmem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic micro_code_t uc(input op_class_e oc, input alu_op_e op, input logic [2:0] f3,
                                     input logic isel, input logic [31:0] imm, input logic [31:0] pc,
                                     input logic [4:0] rd, input logic we, input logic pt,
                                     input logic [31:0] ptgt);
    micro_code_t u;
    u.op_class = oc; u.alu_op = op; u.funct3 = f3; u.imm_sel = isel; u.imm = imm;
    u.pc = pc; u.rd_addr = rd; u.rd_we = we; u.pred_taken = pt; u.pred_target = ptgt;
    return u;
  endfunction

  // Present one op for one cycle; busy is sampled in the accept cycle
  task automatic issue(input micro_code_t u, input logic [31:0] a, input logic [31:0] b,
                       output logic busy);
    exe_microcode = u; rs1_data = a; rs2_data = b; exe_en = 1'b1;
    #1;
    busy = exe_busy;
    @(posedge clk);
    #1;
    exe_en = 1'b0;
  endtask

  task automatic run_alu(input string tag, input alu_op_e op, input logic isel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] exp);
    logic busy;
    issue(uc(OP_ALU, op, 3'b000, isel, imm, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0), a, b, busy);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
    chk({tag, "_rd_addr"}, {27'd0, rd_addr}, 32'd5);
    chk({tag, "_rd_data"}, rd_data, exp);
  endtask

  // Branch/jump issue, then check redirect and that the pulse lasts one cycle
  task automatic run_ctl(input string tag, input micro_code_t u, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_miss, input logic [31:0] exp_pc,
                         input logic exp_rd_en, input logic [31:0] exp_rd);
    logic busy;
    issue(u, a, b, busy);
    chk({tag, "_miss"}, {31'd0, pred_miss}, {31'd0, exp_miss});
    if (exp_miss) chk({tag, "_redirect"}, redirect_pc, exp_pc);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, {31'd0, exp_rd_en});
    if (exp_rd_en) chk({tag, "_rd_data"}, rd_data, exp_rd);
    tick();
    chk({tag, "_miss_drop"}, {31'd0, pred_miss}, 32'd0);
  endtask

  // Load with immediate grant and data the cycle after grant
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp);
    logic busy;
    issue(uc(OP_LOAD, ALU_ADD, f3, 1'b1, imm, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0), base, 32'h0, busy);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_addr"}, dmem_bus.dmem_addr, exp_addr);
    chk({tag, "_be"}, {28'd0, dmem_bus.dmem_be}, {28'd0, exp_be});
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = rdata;
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
    chk({tag, "_rd_data"}, rd_data, exp);
  endtask

  initial begin
    logic busy;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_pred_miss", {31'd0, pred_miss}, 32'd0);
    chk("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_busy", {31'd0, exe_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU operations
    run_alu("add", ALU_ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000);
    chk("add_pulse_next", {31'd0, rd_en}, 32'd1);
    tick();
    chk("add_pulse_drop", {31'd0, rd_en}, 32'd0);
    run_alu("sub", ALU_SUB, 1'b0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF);
    run_alu("sll", ALU_SLL, 1'b0, 32'h1, 32'h3F, 32'h0, 32'h80000000);
    run_alu("slt", ALU_SLT, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1);
    run_alu("sltu", ALU_SLTU, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    run_alu("xor", ALU_XOR, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0);
    run_alu("srl", ALU_SRL, 1'b0, 32'h80000000, 32'h4, 32'h0, 32'h08000000);
    run_alu("srai", ALU_SRA, 1'b1, 32'h80000000, 32'hDEAD0000, 32'h4, 32'hF8000000);
    run_alu("or", ALU_OR, 1'b0, 32'h0F00, 32'h00F0, 32'h0, 32'h0FF0);
    run_alu("andi", ALU_AND, 1'b1, 32'hF0F0, 32'h0, 32'hFF00, 32'hF000);

    // LUI / AUIPC / x0 write suppression
    issue(uc(OP_LUI, ALU_ADD, 3'b000, 1'b1, 32'h12345000, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0), 32'h0, 32'h0, busy);
    chk("lui_rd_data", rd_data, 32'h12345000);
    issue(uc(OP_AUIPC, ALU_ADD, 3'b000, 1'b1, 32'h2000, 32'h1000, 5'd3, 1'b1, 1'b0, 32'h0), 32'h0, 32'h0, busy);
    chk("auipc_rd_data", rd_data, 32'h3000);
    issue(uc(OP_ALU, ALU_ADD, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0), 32'h1, 32'h2, busy);
    chk("add_x0_rd_en", {31'd0, rd_en}, 32'd0);

    // BEQ mispredict, with a wrong-path ADD in the flush cycle
    issue(uc(OP_BRANCH, ALU_ADD, F3_BEQ, 1'b0, 32'h20, 32'h100, 5'd0, 1'b0, 1'b0, 32'h0), 32'h3, 32'h3, busy);
    chk("beq_miss", {31'd0, pred_miss}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h120);
    chk("beq_rd_en", {31'd0, rd_en}, 32'd0);
    exe_microcode = uc(OP_ALU, ALU_ADD, 3'b000, 1'b0, 32'h0, 32'h104, 5'd5, 1'b1, 1'b0, 32'h0);
    rs1_data = 32'h1; rs2_data = 32'h1; exe_en = 1'b1;
    tick();
    exe_en = 1'b0;
    chk("wrongpath_rd_en", {31'd0, rd_en}, 32'd0);
    chk("wrongpath_miss", {31'd0, pred_miss}, 32'd0);
    chk("wrongpath_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

    run_ctl("bne", uc(OP_BRANCH, ALU_ADD, F3_BNE, 1'b0, 32'h20, 32'h100, 5'd0, 1'b0, 1'b0, 32'h0),
            32'h3, 32'h3, 1'b0, 32'h0, 1'b0, 32'h0);
    run_ctl("blt", uc(OP_BRANCH, ALU_ADD, F3_BLT, 1'b0, 32'h20, 32'h100, 5'd0, 1'b0, 1'b1, 32'h120),
            32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    run_ctl("bgeu", uc(OP_BRANCH, ALU_ADD, F3_BGEU, 1'b0, 32'h20, 32'h100, 5'd0, 1'b0, 1'b1, 32'h120),
            32'h1, 32'hFFFFFFFF, 1'b1, 32'h104, 1'b0, 32'h0);
    run_ctl("jalr", uc(OP_JALR, ALU_ADD, 3'b000, 1'b1, 32'h0, 32'h40, 5'd1, 1'b1, 1'b1, 32'h1002),
            32'h1003, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44);
    run_ctl("jal", uc(OP_JAL, ALU_ADD, 3'b000, 1'b1, 32'h10, 32'h200, 5'd1, 1'b1, 1'b0, 32'h0),
            32'h0, 32'h0, 1'b1, 32'h210, 1'b1, 32'h204);

    // LB with grant held off 3 cycles, data 2 cycles after grant
    issue(uc(OP_LOAD, ALU_ADD, F3_LB, 1'b1, 32'h3, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0), 32'h200, 32'h0, busy);
    chk("lb_busy_accept", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("lb_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
      chk("lb_addr", dmem_bus.dmem_addr, 32'h203);
      chk("lb_be", {28'd0, dmem_bus.dmem_be}, 32'h8);
      chk("lb_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
      chk("lb_busy", {31'd0, exe_busy}, 32'd1);
      if (i == 3) dmem_bus.dmem_gnt = 1'b1;
      tick();
    end
    dmem_bus.dmem_gnt = 1'b0;
    chk("lb_req_drop", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("lb_busy_wait", {31'd0, exe_busy}, 32'd1);
    tick();
    chk("lb_busy_wait2", {31'd0, exe_busy}, 32'd1);
    chk("lb_no_early_wb", {31'd0, rd_en}, 32'd0);
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h80FFFFFF;
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    chk("lb_rd_en", {31'd0, rd_en}, 32'd1);
    chk("lb_rd_addr", {27'd0, rd_addr}, 32'd8);
    chk("lb_rd_data", rd_data, 32'hFFFFFF80);
    chk("lb_busy_done", {31'd0, exe_busy}, 32'd0);

    run_load("lhu", F3_LHU, 32'h100, 32'h2, 32'hBEEF1234, 32'h102, 4'b1100, 32'h0000BEEF);
    run_load("lh", F3_LH, 32'h100, 32'h2, 32'hBEEF1234, 32'h102, 4'b1100, 32'hFFFFBEEF);
    run_load("lbu", F3_LBU, 32'h200, 32'h3, 32'h80FFFFFF, 32'h203, 4'b1000, 32'h00000080);
    run_load("lw", F3_LW, 32'h300, 32'h1, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D);

    // SH store: lanes, strobe, busy drop after grant, no writeback
    issue(uc(OP_STORE, ALU_ADD, F3_SH, 1'b1, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0), 32'h100, 32'h1234ABCD, busy);
    chk("sh_busy_accept", {31'd0, busy}, 32'd1);
    chk("sh_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    chk("sh_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
    chk("sh_addr", dmem_bus.dmem_addr, 32'h102);
    chk("sh_be", {28'd0, dmem_bus.dmem_be}, 32'hC);
    chk("sh_wdata", dmem_bus.dmem_wdata, 32'hABCD0000);
    dmem_bus.dmem_gnt = 1'b1;
    #1;
    chk("sh_busy_gnt", {31'd0, exe_busy}, 32'd1);
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    chk("sh_busy_drop", {31'd0, exe_busy}, 32'd0);
    chk("sh_req_drop", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("sh_rd_en", {31'd0, rd_en}, 32'd0);

    // SB store lane
    issue(uc(OP_STORE, ALU_ADD, F3_SB, 1'b1, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0), 32'h100, 32'h55, busy);
    chk("sb_addr", dmem_bus.dmem_addr, 32'h101);
    chk("sb_be", {28'd0, dmem_bus.dmem_be}, 32'h2);
    chk("sb_wdata", dmem_bus.dmem_wdata, 32'h00005500);
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;

    // Reset while waiting for load data; late rvalid must be ignored
    issue(uc(OP_LOAD, ALU_ADD, F3_LW, 1'b1, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0), 32'h300, 32'h0, busy);
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("rstw_busy", {31'd0, exe_busy}, 32'd0);
    chk("rstw_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rstw_addr", dmem_bus.dmem_addr, 32'h0);
    chk("rstw_rd_data", rd_data, 32'h0);
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    chk("rstw_late_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rstw_late_rd_data", rd_data, 32'h0);
    issue(uc(OP_ALU, ALU_ADD, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0), 32'h5, 32'h6, busy);
    chk("rstw_add_x0_rd_en", {31'd0, rd_en}, 32'd0);
    run_alu("rstw_add", ALU_ADD, 1'b0, 32'h5, 32'h6, 32'h0, 32'hB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
